lcd_rx: RTL and testbench

- HD44780-compatible responder: the display end of the 4-bit LCD bus our LCD writer drives.
- Samples RS/RW/E/D[7:4] and tracks 8-bit and 4-bit interface modes.
- Decodes instructions and mirrors DDRAM rows 0/1 (16 columns each) into a 32-byte character buffer.
- Used as a bench/loopback display model and as an on-chip capture of what the writer sends; the buffer read port uses the same 5-bit {row, col} addressing as the writer's memory port.

---
 rtl/lcd_pkg.sv | 60 ++++++
 rtl/lcd_rx_ac.sv | 46 ++++
 rtl/lcd_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_lcd_rx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the lcd_rx HD44780-compatible bus responder.
// Instruction leading-one opcodes, DDRAM window/wrap bounds, default clear fill.
package lcd_pkg;

    localparam logic [7:0] CLEAR_FILL_DEFAULT = 8'h20;

    // Instruction class is selected by the most significant set bit.
    localparam logic [7:0] INS_CLR   = 8'h01;
    localparam logic [7:0] INS_HOME  = 8'h02;
    localparam logic [7:0] INS_ENTRY = 8'h04;
    localparam logic [7:0] INS_DISP  = 8'h08;
    localparam logic [7:0] INS_SHIFT = 8'h10;
    localparam logic [7:0] INS_FUNC  = 8'h20;
    localparam logic [7:0] INS_CGRAM = 8'h40;
    localparam logic [7:0] INS_DDRAM = 8'h80;

    localparam int unsigned ENTRY_ID_BIT = 1;
    localparam int unsigned DISP_D_BIT   = 2;
    localparam int unsigned FUNC_DL_BIT  = 4;

    localparam logic [6:0] WIN0_LO = 7'h00;
    localparam logic [6:0] WIN0_HI = 7'h0F;
    localparam logic [6:0] WIN1_LO = 7'h40;
    localparam logic [6:0] WIN1_HI = 7'h4F;

    localparam logic [6:0] AC_ROW0_START = 7'h00;
    localparam logic [6:0] AC_ROW0_END   = 7'h27;
    localparam logic [6:0] AC_ROW1_START = 7'h40;
    localparam logic [6:0] AC_ROW1_END   = 7'h67;

    typedef enum logic [3:0] {
        I_NOP,
        I_CLR,
        I_HOME,
        I_ENTRY,
        I_DISP,
        I_SHIFT,
        I_FUNC,
        I_CGRAM,
        I_DDRAM
    } ins_e;

    typedef enum logic {
        PH_HI,
        PH_LO
    } phase_e;

    function automatic ins_e ins_decode(input logic [7:0] b);
        if ((b & INS_DDRAM) != '0) return I_DDRAM;
        if ((b & INS_CGRAM) != '0) return I_CGRAM;
        if ((b & INS_FUNC)  != '0) return I_FUNC;
        if ((b & INS_SHIFT) != '0) return I_SHIFT;
        if ((b & INS_DISP)  != '0) return I_DISP;
        if ((b & INS_ENTRY) != '0) return I_ENTRY;
        if ((b & INS_HOME)  != '0) return I_HOME;
        if ((b & INS_CLR)   != '0) return I_CLR;
        return I_NOP;
    endfunction

endpackage

// File: rtl/lcd_rx_ac.sv
// DDRAM address counter for lcd_rx: load, step with row wrap, visible-window
// check and {row, col} buffer index.
module lcd_rx_ac
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ac_load,
    input  logic [6:0] ac_load_val,
    input  logic       ac_step,
    input  logic       ac_inc,
    output logic [6:0] ac,
    output logic       in_win,
    output logic [4:0] buf_idx
);

    logic [6:0] ac_q;
    logic [6:0] ac_d;

    always_comb begin
        ac_d = ac_q;
        if (ac_load) begin
            ac_d = ac_load_val;
        end else if (ac_step) begin
            if (ac_inc) begin
                if (ac_q == AC_ROW0_END)      ac_d = AC_ROW1_START;
                else if (ac_q == AC_ROW1_END) ac_d = AC_ROW0_START;
                else                          ac_d = ac_q + 7'd1;
            end else begin
                if (ac_q == AC_ROW0_START)      ac_d = AC_ROW1_END;
                else if (ac_q == AC_ROW1_START) ac_d = AC_ROW0_END;
                else                            ac_d = ac_q - 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ac_q <= '0;
        else        ac_q <= ac_d;
    end

    assign ac      = ac_q;
    assign in_win  = (ac_q <= WIN0_HI) || ((ac_q >= WIN1_LO) && (ac_q <= WIN1_HI));
    assign buf_idx = {ac_q[6], ac_q[3:0]};

endmodule

// File: rtl/lcd_rx.sv
// HD44780-compatible display-side responder for the 4-bit LCD bus.
// Optional busy flag / status read-back enabled by LCD_RX_BUSY_FLAG_EN.
module lcd_rx
    import lcd_pkg::*;
#(
    parameter logic [7:0] CLEAR_FILL = CLEAR_FILL_DEFAULT
`ifdef LCD_RX_BUSY_FLAG_EN
   ,parameter int unsigned BUSY_CYCLES = 64
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:4] lcd_d,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_pulse,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       mode4,
    output logic       display_on,
    output logic [6:0] ac,
    output logic       proto_err
`ifdef LCD_RX_BUSY_FLAG_EN
   ,output logic [7:4] lcd_d_out,
    output logic       lcd_d_oe
`endif
);

    logic       e_q;
    logic       samp_rs_q, samp_rw_q;
    logic [3:0] samp_d_q;

    phase_e     phase_q, phase_d;
    logic       mode4_q, mode4_d;
    logic [3:0] hi_q, hi_d;
    logic       hi_rs_q, hi_rs_d;
    logic       inc_q, inc_d;
    logic       display_on_q, display_on_d;
    logic       cgram_q, cgram_d;
    logic       wr_pulse_q, wr_pulse_d;
    logic [4:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       proto_err_q, proto_err_d;
    logic [7:0] buf_q [32];
    logic [7:0] buf_d [32];

    logic       strobe, wr_stb, exec, accepted, ex_rs;
    logic [7:0] ex_byte;
    logic       ac_load, ac_step, in_win;
    logic [6:0] ac_load_val;
    logic [4:0] buf_idx;

`ifdef LCD_RX_BUSY_FLAG_EN
    localparam int unsigned BW = $clog2(BUSY_CYCLES + 1);
    logic [BW-1:0] busy_cnt_q, busy_cnt_d;
    logic          rd_ph_q, rd_ph_d;
    logic          bf;
    assign bf = (busy_cnt_q != '0);
`endif

    lcd_rx_ac u_ac (
        .clk         (clk),
        .rst_n       (rst_n),
        .ac_load     (ac_load),
        .ac_load_val (ac_load_val),
        .ac_step     (ac_step),
        .ac_inc      (inc_q),
        .ac          (ac),
        .in_win      (in_win),
        .buf_idx     (buf_idx)
    );

    // Bus fields are sampled every cycle, so on the E fall they hold the last E-high cycle.
    assign strobe = e_q & ~lcd_e;
    assign wr_stb = strobe & ~samp_rw_q;

    always_comb begin
        phase_d      = phase_q;
        mode4_d      = mode4_q;
        hi_d         = hi_q;
        hi_rs_d      = hi_rs_q;
        inc_d        = inc_q;
        display_on_d = display_on_q;
        cgram_d      = cgram_q;
        wr_pulse_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        proto_err_d  = 1'b0;
        buf_d        = buf_q;
        exec         = 1'b0;
        accepted     = 1'b0;
        ex_rs        = 1'b0;
        ex_byte      = '0;
        ac_load      = 1'b0;
        ac_load_val  = '0;
        ac_step      = 1'b0;

        if (wr_stb) begin
            if (!mode4_q) begin
                if (!samp_rs_q && samp_d_q == 4'h2) begin
                    mode4_d     = 1'b1;
                    phase_d     = PH_HI;
                    cmd_valid_d = 1'b1;
                    cmd_byte_d  = 8'h20;
                    accepted    = 1'b1;
                end else if (!samp_rs_q && samp_d_q == 4'h3) begin
                    cmd_valid_d = 1'b1;
                    cmd_byte_d  = 8'h30;
                    accepted    = 1'b1;
                end
            end else if (phase_q == PH_HI) begin
                hi_d    = samp_d_q;
                hi_rs_d = samp_rs_q;
                phase_d = PH_LO;
            end else begin
                phase_d     = PH_HI;
                exec        = 1'b1;
                accepted    = 1'b1;
                ex_rs       = samp_rs_q;
                ex_byte     = {hi_q, samp_d_q};
                proto_err_d = (hi_rs_q != samp_rs_q);
            end
        end

        if (exec) begin
            if (!ex_rs) begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = ex_byte;
                case (ins_decode(ex_byte))
                    I_CLR: begin
                        for (int unsigned i = 0; i < 32; i++) buf_d[i] = CLEAR_FILL;
                        ac_load     = 1'b1;
                        ac_load_val = AC_ROW0_START;
                        inc_d       = 1'b1;
                    end
                    I_HOME: begin
                        ac_load     = 1'b1;
                        ac_load_val = AC_ROW0_START;
                    end
                    I_ENTRY: inc_d        = ex_byte[ENTRY_ID_BIT];
                    I_DISP:  display_on_d = ex_byte[DISP_D_BIT];
                    I_FUNC: begin
                        if (ex_byte[FUNC_DL_BIT]) begin
                            mode4_d = 1'b0;
                            phase_d = PH_HI;
                        end
                    end
                    I_CGRAM: cgram_d = 1'b1;
                    I_DDRAM: begin
                        ac_load     = 1'b1;
                        ac_load_val = ex_byte[6:0];
                        cgram_d     = 1'b0;
                    end
                    default: ;
                endcase
            end else if (!cgram_q) begin
                if (in_win) begin
                    buf_d[buf_idx] = ex_byte;
                    wr_pulse_d     = 1'b1;
                    wr_addr_d      = buf_idx;
                    wr_data_d      = ex_byte;
                end
                ac_step = 1'b1;
            end
        end

`ifdef LCD_RX_BUSY_FLAG_EN
        busy_cnt_d = busy_cnt_q;
        rd_ph_d    = rd_ph_q;
        if (accepted)  busy_cnt_d = BW'(BUSY_CYCLES);
        else if (bf)   busy_cnt_d = busy_cnt_q - 1'b1;
        if (wr_stb && bf) proto_err_d = 1'b1;
        if (strobe && samp_rw_q && !samp_rs_q && mode4_q) rd_ph_d = ~rd_ph_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q          <= 1'b0;
            samp_rs_q    <= 1'b0;
            samp_rw_q    <= 1'b0;
            samp_d_q     <= '0;
            phase_q      <= PH_HI;
            mode4_q      <= 1'b0;
            hi_q         <= '0;
            hi_rs_q      <= 1'b0;
            inc_q        <= 1'b1;
            display_on_q <= 1'b0;
            cgram_q      <= 1'b0;
            wr_pulse_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            proto_err_q  <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) buf_q[i] <= CLEAR_FILL;
        end else begin
            e_q          <= lcd_e;
            samp_rs_q    <= lcd_rs;
            samp_rw_q    <= lcd_rw;
            samp_d_q     <= lcd_d;
            phase_q      <= phase_d;
            mode4_q      <= mode4_d;
            hi_q         <= hi_d;
            hi_rs_q      <= hi_rs_d;
            inc_q        <= inc_d;
            display_on_q <= display_on_d;
            cgram_q      <= cgram_d;
            wr_pulse_q   <= wr_pulse_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            proto_err_q  <= proto_err_d;
            buf_q        <= buf_d;
        end
    end

`ifdef LCD_RX_BUSY_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
            rd_ph_q    <= 1'b0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            rd_ph_q    <= rd_ph_d;
        end
    end

    assign lcd_d_oe  = lcd_e & lcd_rw & ~lcd_rs;
    assign lcd_d_out = rd_ph_q ? ac[3:0] : {bf, ac[6:4]};
`endif

    assign rd_data    = buf_q[rd_addr];
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign mode4      = mode4_q;
    assign display_on = display_on_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx: drives writer-style strobes, checks with immediate assertions.
module tb_lcd_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:4] lcd_d = '0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       wr_pulse;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       mode4, display_on, proto_err;
    logic [6:0] ac;
`ifdef LCD_RX_BUSY_FLAG_EN
    logic [7:4] lcd_d_out;
    logic       lcd_d_oe;
`endif

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int proto_cnt = 0;
    logic [4:0] last_wa = '0;
    logic [7:0] last_wd = '0;
    logic [7:0] cmdq [$];

    always #5 clk = ~clk;

    lcd_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_d      (lcd_d),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .mode4      (mode4),
        .display_on (display_on),
        .ac         (ac),
        .proto_err  (proto_err)
`ifdef LCD_RX_BUSY_FLAG_EN
       ,.lcd_d_out  (lcd_d_out),
        .lcd_d_oe   (lcd_d_oe)
`endif
    );

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) cmdq.push_back(cmd_byte);
        if (wr_pulse === 1'b1) begin
            wr_cnt++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (proto_err === 1'b1) proto_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_d = d; lcd_e = 1'b1;
        @(negedge clk);
        lcd_e = 1'b0;
        @(negedge clk);
        @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic byte4(input logic rs, input logic [7:0] b);
        strobe(rs, 1'b0, b[7:4]);
        strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic chk_fill(input string tag);
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            if (rd_data !== 8'h20) bad++;
        end
        chk(tag, 32'(bad), 0);
    endtask

`ifdef LCD_RX_BUSY_FLAG_EN
    task automatic rd_nib(input string tag, input logic [3:0] exp);
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
        @(negedge clk);
        chk({tag, "_oe"}, 32'(lcd_d_oe), 1);
        chk(tag, 32'(lcd_d_out), 32'(exp));
        lcd_e = 1'b0;
        @(negedge clk);
        @(negedge clk);
        lcd_rw = 1'b0;
    endtask
`endif

    initial begin
        int p0;
        int q0;
        repeat (3) @(negedge clk);
        chk("rst_mode4", 32'(mode4), 0);
        chk("rst_ac", 32'(ac), 0);
        chk("rst_disp", 32'(display_on), 0);
        chk("rst_pulses", 32'({cmd_valid, wr_pulse, proto_err}), 0);
        chk_rd("rst_rd5", 5'd5, 8'h20);
        @(negedge clk);
        rst_n = 1'b1;

        // Writer init sequence
        strobe(1'b0, 1'b0, 4'h2);
        byte4(1'b0, 8'h28);
        byte4(1'b0, 8'h0C);
        byte4(1'b0, 8'h01);
        byte4(1'b0, 8'h06);
        chk("init_mode4", 32'(mode4), 1);
        chk("init_disp", 32'(display_on), 1);
        chk("init_ac", 32'(ac), 0);
        chk("init_ncmd", 32'(cmdq.size()), 5);
        chk("init_cmd0", 32'(cmdq[0]), 'h20);
        chk("init_cmd1", 32'(cmdq[1]), 'h28);
        chk("init_cmd2", 32'(cmdq[2]), 'h0C);
        chk("init_cmd3", 32'(cmdq[3]), 'h01);
        chk("init_cmd4", 32'(cmdq[4]), 'h06);
        chk_fill("init_fill");
        chk("init_wr", 32'(wr_cnt), 0);

        byte4(1'b1, 8'h48);
        byte4(1'b1, 8'h69);
        chk_rd("hi_rd0", 5'd0, 8'h48);
        chk_rd("hi_rd1", 5'd1, 8'h69);
        chk("hi_ac", 32'(ac), 'h02);
        chk("hi_wr", 32'(wr_cnt), 2);
        chk("hi_wa", 32'(last_wa), 1);
        chk("hi_wd", 32'(last_wd), 'h69);

        byte4(1'b0, 8'hC0);
        byte4(1'b1, 8'h41);
        chk_rd("row1_rd16", 5'd16, 8'h41);
        chk("row1_ac", 32'(ac), 'h41);
        chk("row1_wa", 32'(last_wa), 16);

        // Off-window address: steps, wraps, never writes
        byte4(1'b0, 8'hA7);
        byte4(1'b1, 8'h55);
        chk("wrap27_ac", 32'(ac), 'h40);
        chk("wrap27_wr", 32'(wr_cnt), 3);
        chk_rd("wrap27_rd7", 5'd7, 8'h20);

        byte4(1'b0, 8'h04);
        byte4(1'b0, 8'h80);
        byte4(1'b1, 8'h5A);
        chk_rd("dec_rd0", 5'd0, 8'h5A);
        chk("dec00_ac", 32'(ac), 'h67);
        byte4(1'b0, 8'hC0);
        byte4(1'b1, 8'h5B);
        chk_rd("dec_rd16", 5'd16, 8'h5B);
        chk("dec40_ac", 32'(ac), 'h27);
        chk("dec_wr", 32'(wr_cnt), 5);

        byte4(1'b0, 8'h40);
        byte4(1'b1, 8'h77);
        chk("cgram_ac", 32'(ac), 'h27);
        chk("cgram_wr", 32'(wr_cnt), 5);
        byte4(1'b0, 8'h80);
        byte4(1'b0, 8'h06);

        p0 = proto_cnt;
        strobe(1'b0, 1'b0, 4'h4);
        strobe(1'b1, 1'b0, 4'h3);
`ifdef LCD_RX_BUSY_FLAG_EN
        chk("proto_cnt", 32'(proto_cnt - p0), 2);
`else
        chk("proto_cnt", 32'(proto_cnt - p0), 1);
`endif
        chk_rd("proto_rd0", 5'd0, 8'h43);
        chk("proto_ac", 32'(ac), 'h01);

        byte4(1'b0, 8'h08);
        chk("dispoff", 32'(display_on), 0);
        byte4(1'b0, 8'h02);
        chk("home_ac", 32'(ac), 0);

`ifndef LCD_RX_BUSY_FLAG_EN
        q0 = cmdq.size();
        strobe(1'b0, 1'b1, 4'h8);
        strobe(1'b0, 1'b1, 4'h1);
        chk("read_ign", 32'(cmdq.size() - q0), 0);
`endif

        // Reset with one nibble latched
        strobe(1'b1, 1'b0, 4'h7);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_mode4", 32'(mode4), 0);
        chk("mrst_ac", 32'(ac), 0);
        chk_rd("mrst_rd0", 5'd0, 8'h20);
        chk_rd("mrst_rd16", 5'd16, 8'h20);

        strobe(1'b0, 1'b0, 4'h2);
        byte4(1'b1, 8'h31);
        chk_rd("re4_rd0", 5'd0, 8'h31);
        byte4(1'b0, 8'h30);
        chk("dl8_mode4", 32'(mode4), 0);
        strobe(1'b1, 1'b0, 4'h4);
        chk("m8_ign_wr", 32'(wr_cnt), 7);
        strobe(1'b0, 1'b0, 4'h3);
        chk("m8_cmd30", 32'(cmdq[$]), 'h30);
        chk("m8_mode4", 32'(mode4), 0);
        strobe(1'b0, 1'b0, 4'h2);
        byte4(1'b1, 8'h4B);
        chk_rd("m4_rd1", 5'd1, 8'h4B);
        byte4(1'b0, 8'h01);
        chk_fill("clr_fill");
        chk("clr_ac", 32'(ac), 0);

        byte4(1'b0, 8'hC5);
        byte4(1'b1, 8'h2A);
        chk_rd("c5_rd21", 5'd21, 8'h2A);
        chk("c5_ac", 32'(ac), 'h46);
`ifdef LCD_RX_BUSY_FLAG_EN
        rd_nib("bf_hi", 4'hC);
        rd_nib("bf_lo", 4'h6);
        repeat (80) @(negedge clk);
        rd_nib("idle_hi", 4'h4);
        rd_nib("idle_lo", 4'h6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
